// File: rtl/multicycle_control.sv
// Multicycle sequencer: instruction-phase FSM, ALU/flag decode, NZCV flag register
// and condition evaluation driving the shared-ALU / unified-memory datapath.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] ALUControl,
  output logic [3:0] Flags,
  output logic [3:0] state_dbg
);

  // FETCH is encoded as 0 so a reset FSM reads back as all-zero on state_dbg.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state, state_next;
  logic [3:0] cmd;
  logic       no_wb;
  logic       next_pc, branch, reg_w, mem_w, alu_op;
  logic       cond_ex, cond_ok, pcs;
  logic [3:0] flag_w;
  logic [3:0] flag_mask;

  assign cmd       = Funct[4:1];
  // TST/TEQ/CMP/CMN (8..B) only set flags and skip the writeback state.
  assign no_wb     = (cmd[3:2] == 2'b10);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:    state_next = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_next = MEMWB;
      EXECUTER: state_next = no_wb ? FETCH : ALUWB;
      EXECUTEI: state_next = no_wb ? FETCH : ALUWB;
      default:  state_next = FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    next_pc   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMRD:    AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB:    reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (Op)
      2'b01: begin
        ImmSrc = 2'b01;
        RegSrc = Funct[0] ? 2'b00 : 2'b10;
      end
      2'b10: begin
        ImmSrc = 2'b10;
        RegSrc = 2'b01;
      end
      default: ;
    endcase
  end

  assign ALUControl = alu_op ? cmd : 4'h4;

  always_comb begin
    flag_w = 4'b0000;
    if (alu_op) begin
      if (Funct[0]) flag_w = 4'b1110;
      if (cmd == 4'hA || cmd == 4'hB)      flag_w      = 4'b1111;
      else if (cmd == 4'h8 || cmd == 4'h9) flag_w[3:1] = 3'b111;
    end
  end

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'h0: cond_ex = Flags[2];
      4'h1: cond_ex = !Flags[2];
      4'h2: cond_ex = Flags[1];
      4'h3: cond_ex = !Flags[1];
      4'h4: cond_ex = Flags[3];
      4'h5: cond_ex = !Flags[3];
      4'h6: cond_ex = Flags[0];
      4'h7: cond_ex = !Flags[0];
      4'h8: cond_ex = Flags[1] && !Flags[2];
      4'h9: cond_ex = !Flags[1] || Flags[2];
      4'hA: cond_ex = (Flags[3] == Flags[0]);
      4'hB: cond_ex = (Flags[3] != Flags[0]);
      4'hC: cond_ex = !Flags[2] && (Flags[3] == Flags[0]);
      4'hD: cond_ex = Flags[2] || (Flags[3] != Flags[0]);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Only the flag bits selected by flag_w are overwritten, and only when the instruction executes.
  assign flag_mask = cond_ok ? flag_w : 4'b0000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cond_ok <= 1'b0;
      Flags   <= 4'b0000;
    end else begin
      if (state == DECODE) cond_ok <= cond_ex;
      Flags <= (Flags & ~flag_mask) | (ALUFlags & flag_mask);
    end
  end

  assign pcs      = branch | (reg_w & (Rd == 4'hF));
  assign RegWrite = reg_w & cond_ok;
  assign MemWrite = mem_w & cond_ok;
  assign PCWrite  = next_pc | (pcs & cond_ok);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: reset checks, a directed instruction table, a
// mid-instruction reset sequence, and random instructions against a cycle-list model.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [3:0] ALUControl, Flags, state_dbg;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [21:0] exp_q[$];
  logic [3:0]  mflags;

  typedef struct {
    string      name;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] aluf;
    int         cycles;
    logic [3:0] flags;
    logic [2:0] we;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [21:0] pack(input logic ir, input logic pcw, input logic rw,
      input logic mw, input logic adr, input logic srca, input logic [1:0] srcb,
      input logic [1:0] res, input logic [3:0] aluc, input logic [1:0] imm,
      input logic [1:0] rsrc, input logic [3:0] fl);
    return {ir, pcw, rw, mw, adr, srca, srcb, res, aluc, imm, rsrc, fl};
  endfunction

  function automatic logic [21:0] dut_vec();
    return pack(IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
                ResultSrc, ALUControl, ImmSrc, RegSrc, Flags);
  endfunction

  // ARM condition codes: pairs share a base test, odd codes invert it; 1111 is never.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, r;
    {n, z, cc, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cc;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cc && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return c[0] ? !r : r;
  endfunction

  task automatic drive(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input logic [3:0] af);
    Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
  endtask

  // driver: entered just after the edge that lands in FETCH; counts cycles back to FETCH.
  task automatic measure(input vec_t t);
    int n;
    bit done;
    logic [2:0] last_we;
    drive(t.cond, t.op, t.funct, t.rd, t.aluf);
    n = 0; done = 0; last_we = 3'b000;
    while (!done) begin
      #1;
      last_we = {PCWrite, RegWrite, MemWrite};
      n++;
      @(posedge clk); #1;
      if (IRWrite) done = 1;
      else if (n >= 12) begin
        $display("FAIL %s_timeout: no return to FETCH within %0d cycles", t.name, n);
        n_fail++;
        done = 1;
      end
    end
    check({t.name, "_cycles"}, 32'(n), 32'(t.cycles));
    check({t.name, "_flags"}, 32'(Flags), 32'(t.flags));
    check({t.name, "_we"}, 32'(last_we), 32'(t.we));
    mflags = t.flags;
  endtask

  // reference model: the instruction's whole cycle list is queued up front, then compared cycle by cycle.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input logic [3:0] af);
    logic [1:0] imm, rsrc;
    logic [3:0] cmd, mask;
    bit ce, pcd;
    int cyc;
    drive(c, op, f, rd, af);
    ce   = cond_holds(c, mflags);
    pcd  = (rd == 4'hF);
    cmd  = f[4:1];
    imm  = (op == 2'd1) ? 2'd1 : (op == 2'd2) ? 2'd2 : 2'd0;
    rsrc = (op == 2'd2) ? 2'd1 : ((op == 2'd1) && !f[0]) ? 2'd2 : 2'd0;
    exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 4'h4, imm, rsrc, mflags));
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 4'h4, imm, rsrc, mflags));
    case (op)
      2'd0: begin
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {1'b0, f[5]}, 2'd0, cmd,
                             imm, rsrc, mflags));
        if (cmd == 4'hA || cmd == 4'hB)                mask = 4'hF;
        else if (f[0] || cmd == 4'h8 || cmd == 4'h9)   mask = 4'hE;
        else                                           mask = 4'h0;
        if (ce) mflags = (mflags & ~mask) | (af & mask);
        if (!(cmd >= 4'h8 && cmd <= 4'hB))
          exp_q.push_back(pack(1'b0, ce && pcd, ce, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'h4,
                               imm, rsrc, mflags));
      end
      2'd1: begin
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 4'h4, imm, rsrc, mflags));
        if (f[0]) begin
          exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'h4, imm, rsrc, mflags));
          exp_q.push_back(pack(1'b0, ce && pcd, ce, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 4'h4,
                               imm, rsrc, mflags));
        end else begin
          exp_q.push_back(pack(1'b0, 1'b0, 1'b0, ce, 1'b1, 1'b0, 2'd0, 2'd0, 4'h4, imm, rsrc, mflags));
        end
      end
      2'd2: exp_q.push_back(pack(1'b0, ce, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 4'h4,
                                 imm, rsrc, mflags));
      default: ;
    endcase
    cyc = 0;
    while (exp_q.size() > 0) begin
      #1;
      check($sformatf("rand_c%0h_op%0d_f%02h_cyc%0d", c, op, f, cyc), 32'(dut_vec()),
            32'(exp_q.pop_front()));
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic add(input string nm, input logic [3:0] c, input logic [1:0] op,
                     input logic [5:0] f, input logic [3:0] rd, input logic [3:0] af,
                     input int cy, input logic [3:0] fl, input logic [2:0] we);
    vec_t t;
    t.name = nm; t.cond = c; t.op = op; t.funct = f; t.rd = rd; t.aluf = af;
    t.cycles = cy; t.flags = fl; t.we = we;
    tbl.push_back(t);
  endtask

  initial begin
    // expected we = {PCWrite, RegWrite, MemWrite} in the last cycle before FETCH
    add("add_imm",  4'hE, 2'd0, 6'b101000, 4'h1, 4'hF, 4, 4'b0000, 3'b010);
    add("ldr",      4'hE, 2'd1, 6'b011001, 4'h2, 4'h0, 5, 4'b0000, 3'b010);
    add("str",      4'hE, 2'd1, 6'b011000, 4'h3, 4'h0, 4, 4'b0000, 3'b001);
    add("cmp",      4'hE, 2'd0, 6'b010101, 4'h0, 4'h4, 3, 4'b0100, 3'b000);
    add("beq",      4'h0, 2'd2, 6'b000000, 4'h0, 4'h0, 3, 4'b0100, 3'b100);
    add("bne",      4'h1, 2'd2, 6'b000000, 4'h0, 4'h0, 3, 4'b0100, 3'b000);
    add("subs_pc",  4'hE, 2'd0, 6'b000101, 4'hF, 4'h9, 4, 4'b1000, 3'b110);
    add("subs_neq", 4'h0, 2'd0, 6'b000101, 4'hF, 4'h6, 4, 4'b1000, 3'b000);
    add("op11",     4'hE, 2'd3, 6'b000000, 4'h0, 4'hF, 2, 4'b1000, 3'b000);
    add("tst",      4'hE, 2'd0, 6'b010000, 4'h0, 4'h7, 3, 4'b0110, 3'b000);
    add("cmn_nexe", 4'h1, 2'd0, 6'b010110, 4'h0, 4'hF, 3, 4'b0110, 3'b000);
    add("ldr_pc",   4'hE, 2'd1, 6'b011001, 4'hF, 4'h0, 5, 4'b0110, 3'b110);
    add("cond_nv",  4'hF, 2'd0, 6'b101000, 4'h1, 4'hF, 4, 4'b0110, 3'b000);

    // reset held low three cycles
    reset = 1'b0;
    mflags = 4'b0000;
    drive(4'hE, 2'd3, 6'b000000, 4'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_state", 32'(state_dbg), 32'd0);
    check("rst_hold_we", 32'({IRWrite, PCWrite, RegWrite, MemWrite}), 32'b1100);
    reset = 1'b1;
    #1;
    check("rst_rel_we", 32'({IRWrite, PCWrite, RegWrite, MemWrite}), 32'b1100);
    check("rst_rel_flags", 32'(Flags), 32'd0);
    @(posedge clk); #1;
    check("rst_decode", 32'({IRWrite, ALUSrcA, ALUSrcB}), 32'b0110);
    @(posedge clk); #1;
    check("rst_back_fetch", 32'(IRWrite), 32'd1);

    for (int i = 0; i < tbl.size(); i++) measure(tbl[i]);

    // reset pulled low in the middle of a store's MEMWR cycle
    drive(4'hE, 2'd1, 6'b011000, 4'h4, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_memwr", 32'({MemWrite, AdrSrc}), 32'b11);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_we", 32'({IRWrite, PCWrite, RegWrite, MemWrite}), 32'b1100);
    check("midrst_flags", 32'(Flags), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    mflags = 4'b0000;

    for (int i = 0; i < 200; i++) begin
      logic [3:0] rc, rrd, raf;
      logic [1:0] rop;
      logic [5:0] rf;
      rc  = 4'($urandom_range(0, 15));
      rop = 2'($urandom_range(0, 3));
      rf  = 6'($urandom_range(0, 63));
      rrd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      raf = 4'($urandom_range(0, 15));
      run_instr(rc, rop, rf, rrd, raf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
